fetch_cycle: RTL



---
 rtl/fetch_cycle.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: fetch PC, single-outstanding memory handshake,
// one-entry hold buffer for stalls, and the IF/ID pipeline register.
module fetch_cycle (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        IF_en,
    input  logic        IF_rst_n,
    input  logic        EX_pc_sel,
    input  logic [31:0] EX_pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_pc_four,
    output logic        ID_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        accept;

    assign pc_plus4 = pc_q + 32'd4;

    // Request is combinational so an accepted word can chain the next fetch
    // in the same cycle; gating with rst_ni keeps it low while in reset.
    always_comb begin
        accept    = (state_q == S_WAIT) && imem_rvalid && !EX_pc_sel;
        imem_req  = rst_ni && (((state_q == S_REQ) && !buf_valid && !EX_pc_sel)
                               || (accept && IF_en));
        imem_addr = (accept && IF_en) ? pc_plus4 : pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_REQ;
            pc_q       <= '0;
            buf_valid  <= 1'b0;
            buf_inst   <= '0;
            buf_pc     <= '0;
            ID_inst    <= NOP;
            ID_pc      <= '0;
            ID_pc_four <= '0;
            ID_valid   <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (!buf_valid && !EX_pc_sel) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (EX_pc_sel)        state_q <= imem_rvalid ? S_REQ : S_DROP;
                    else if (imem_rvalid) state_q <= IF_en ? S_WAIT : S_REQ;
                end
                S_DROP: begin
                    if (imem_rvalid) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase

            if (EX_pc_sel)   pc_q <= EX_pc_target;
            else if (accept) pc_q <= pc_plus4;

            if (EX_pc_sel) begin
                buf_valid <= 1'b0;
            end else if (accept && !IF_en) begin
                buf_valid <= 1'b1;
                buf_inst  <= imem_rdata;
                buf_pc    <= pc_q;
            end else if (IF_en) begin
                buf_valid <= 1'b0;
            end

            // Flush wins over advance; a word accepted this cycle is dropped.
            if (!IF_rst_n) begin
                ID_inst    <= NOP;
                ID_pc      <= '0;
                ID_pc_four <= '0;
                ID_valid   <= 1'b0;
            end else if (IF_en) begin
                if (buf_valid) begin
                    ID_inst    <= buf_inst;
                    ID_pc      <= buf_pc;
                    ID_pc_four <= buf_pc + 32'd4;
                    ID_valid   <= 1'b1;
                end else if (accept) begin
                    ID_inst    <= imem_rdata;
                    ID_pc      <= pc_q;
                    ID_pc_four <= pc_plus4;
                    ID_valid   <= 1'b1;
                end else begin
                    ID_inst    <= NOP;
                    ID_valid   <= 1'b0;
                end
            end
        end
    end

endmodule
